timer_ctrl: RTL
===============

TIMER_CTRL -- requirements
Module: timer_ctrl

Interface
REQ-001 Parameter: WIDTH, 26, bit width of load value and count register.
REQ-002 Port: clk  input  1  system clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous and active-high.
REQ-004 Port: start  input  1  level-sampled command: load load_val and begin counting.
REQ-005 Port: stop  input  1  level-sampled command: abort and return to IDLE.
REQ-006 Port: pause  input  1  level-sampled: hold count while high.
REQ-007 Port: auto_reload  input  1  sampled at start: 1 = periodic, 0 = one-shot.
REQ-008 Port: load_val  input  WIDTH  terminal reload value N, sampled at start.
REQ-009 Port: count  output  WIDTH  current down-counter value, registered.
REQ-010 Port: busy  output  1  high in RUN or PAUSE, registered.
REQ-011 Port: done  output  1  one-cycle terminal pulse, registered.
REQ-012 Port: state  output  2  FSM state: IDLE=00, RUN=01, PAUSE=10.

Function
REQ-013 FSM SHALL have exactly three states, IDLE, RUN and PAUSE; encoding 11 is unreachable and SHALL recover to IDLE on the next edge.
REQ-014 Command priority per edge SHALL be stop > pause > start.
REQ-015 On an edge with stop=1 in any state, the FSM SHALL go to IDLE, count SHALL be set to 0, and done SHALL be 0.
REQ-016 In IDLE with start=1 and stop=0, the FSM SHALL go to RUN, count SHALL be set to load_val, and load_val and auto_reload SHALL be latched into internal reload registers.
REQ-017 In RUN with count>0 and pause=0, count SHALL decrement by 1 on each edge.
REQ-018 In RUN with count==0 and pause=0 (terminal edge), done SHALL be 1 for exactly the following cycle.
REQ-019 On a one-shot terminal edge, the FSM SHALL go to IDLE and count SHALL remain 0.
REQ-020 On an auto-reload terminal edge, the FSM SHALL stay in RUN and count SHALL be set to the latched reload value; the period SHALL be N+1 cycles.
REQ-021 First done after start SHALL be visible N+1 cycles after the start edge; N=0 SHALL give done on the edge after start.
REQ-022 In RUN with start=1, pause=0 and stop=0, the counter SHALL restart: reload count from the current load_val, re-latch auto_reload, and suppress done on that edge.
REQ-023 In RUN with pause=1 (stop=0), the FSM SHALL enter PAUSE, count SHALL be held, and no done SHALL occur, even on a terminal edge.
REQ-024 In PAUSE with pause=0 (stop=0), the FSM SHALL return to RUN with count unchanged; start SHALL be ignored in PAUSE.
REQ-025 Count SHALL never underflow; all arithmetic is unsigned WIDTH-bit.
REQ-026 busy SHALL be registered and equal (next state != IDLE); done SHALL be 0 in every cycle except those defined in REQ-018.

Reset
REQ-027 While rst=1, regardless of clk: state=IDLE, count=0, busy=0, done=0, and reload registers = 0.
REQ-028 Reset asserted mid-count SHALL abort immediately with no done pulse.
REQ-029 The first edge after rst deasserts SHALL be evaluated as a normal IDLE cycle.

Verification
REQ-030 One-shot: load_val=5, auto_reload=0, start pulse -> count 5,4,3,2,1,0; done=1 exactly 6 cycles after start; then IDLE with busy=0.
REQ-031 Auto-reload: load_val=3, auto_reload=1 -> done pulses every 4 cycles, at least 3 periods; count sequence 3,2,1,0,3,...
REQ-032 Pause: load_val=10, pause high 4 cycles at count=6 -> count held at 6, state=10, busy=1; done delayed by exactly 4 cycles.
REQ-033 Conflicts: stop+pause+start together in RUN -> IDLE, count=0; stop on terminal edge -> no done; start mid-run at count=2 with load_val=7 -> count=7, no done.
REQ-034 Edges: load_val=0 one-shot -> done on edge after start; load_val=2^26-1 -> decrements without wrap; rst pulse mid-count (count=4) -> immediate IDLE, count=0, no done.

Source files
------------

// File: rtl/timer_ctrl.sv
// timer_ctrl: down-counting timer with start/stop/pause commands, one-shot or auto-reload
// Ports: clk; rst (asynchronous, active-high); start, stop, pause (level-sampled commands,
// priority stop > pause > start); auto_reload and load_val (latched on start);
// count (registered down-counter); busy (registered, high in RUN/PAUSE);
// done (registered one-cycle terminal pulse); state (IDLE=00, RUN=01, PAUSE=10).
module timer_ctrl #(
   parameter int WIDTH = 26
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             stop,
   input  logic             pause,
   input  logic             auto_reload,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] count,
   output logic             busy,
   output logic             done,
   output logic [1:0]       state
);
   typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, PAUSE = 2'b10} state_t;
   state_t           st;
   logic [WIDTH-1:0] reload;
   logic             reload_ar;
   assign state = st;
   // busy is written on every path alongside st so it always equals (next state != IDLE)
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st        <= IDLE;
         count     <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         reload    <= '0;
         reload_ar <= 1'b0;
      end else begin
         done <= 1'b0;
         if (stop) begin
            st    <= IDLE;
            count <= '0;
            busy  <= 1'b0;
         end else begin
            case (st)
               IDLE: if (start) begin
                  st        <= RUN;
                  count     <= load_val;
                  reload    <= load_val;
                  reload_ar <= auto_reload;
                  busy      <= 1'b1;
               end
               RUN: begin
                  // pause wins over start and also swallows a terminal edge
                  if (pause) st <= PAUSE;
                  else if (start) begin
                     count     <= load_val;
                     reload    <= load_val;
                     reload_ar <= auto_reload;
                  end else if (count != '0) count <= count - WIDTH'(1);
                  else begin
                     done <= 1'b1;
                     if (reload_ar) count <= reload;
                     else begin
                        st   <= IDLE;
                        busy <= 1'b0;
                     end
                  end
               end
               PAUSE: if (!pause) st <= RUN;
               default: begin
                  st    <= IDLE;
                  count <= '0;
                  busy  <= 1'b0;
               end
            endcase
         end
      end
   end
endmodule
